// File: rtl/multi_master_arbiter_if.sv
// ============================================================================
// multi_master_arbiter_if : request/grant/split bundle for multi_master_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface multi_master_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3,
  parameter int SLAVE_LEN   = 2
);
  localparam int ID_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]           m_request;
  logic [NUM_MASTERS*SLAVE_LEN-1:0] m_slave_sel;
  logic                             trans_done;
  logic [NUM_SLAVES-1:0]            s_split_en;
  logic [NUM_SLAVES-1:0]            s_split_resume;
  logic [NUM_MASTERS-1:0]           m_grant;
  logic [ID_W-1:0]                  grant_id;
  logic [SLAVE_LEN-1:0]             slave_sel;
  logic                             arbiter_busy;
  logic                             bus_busy;
  logic [NUM_SLAVES-1:0]            split_pending;
  logic                             timeout;

  modport master (
    output m_request, m_slave_sel, trans_done, s_split_en, s_split_resume,
    input  m_grant, grant_id, slave_sel, arbiter_busy, bus_busy, split_pending, timeout
  );

  modport slave (
    input  m_request, m_slave_sel, trans_done, s_split_en, s_split_resume,
    output m_grant, grant_id, slave_sel, arbiter_busy, bus_busy, split_pending, timeout
  );
endinterface

`default_nettype wire

// File: rtl/multi_master_arbiter.sv
// ============================================================================
// multi_master_arbiter : IDLE/GRANT/BUSY bus arbiter with split/resume parking.
// ARB_WATCHDOG_EN adds a BUSY-cycle watchdog.                        Rev 1.0
// ============================================================================
`default_nettype none

module multi_master_arbiter #(
  parameter int NUM_MASTERS       = 4,
  parameter int NUM_SLAVES        = 3,
  parameter int SLAVE_LEN         = 2,
  parameter int ROUND_ROBIN       = 1,
  parameter int MAX_COUNT_TIMEOUT = 100
) (
  input  wire logic             clk,
  input  wire logic             reset,
  multi_master_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_MASTERS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [ID_W-1:0]        r_grant_id;
  logic [SLAVE_LEN-1:0]   r_slave_sel;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [NUM_SLAVES-1:0]  r_split_pending;
  logic [ID_W-1:0]        r_parked_id [NUM_SLAVES];
  logic                   r_resume_valid;
  logic [ID_W-1:0]        r_resume_id;
  logic                   r_timeout;

  logic [NUM_SLAVES-1:0]  w_resume_hit;
  logic [NUM_SLAVES-1:0]  w_pending_kept;
  logic [NUM_MASTERS-1:0] w_parked;
  logic [NUM_MASTERS-1:0] w_eligible;
  logic                   w_new_res_valid;
  logic [ID_W-1:0]        w_new_res_id;
  logic                   w_win_valid;
  logic [ID_W-1:0]        w_win_id;
  logic [NUM_SLAVES-1:0]  w_split_set;
  logic                   w_split_fire;
  logic                   w_wd_fire;
  logic                   w_release;
  logic                   w_arbiter_busy;
  logic                   w_bus_busy;

  // Resume pulses for empty slots are dropped here.
  assign w_resume_hit   = bus.s_split_resume & r_split_pending;
  assign w_pending_kept = r_split_pending & ~w_resume_hit;

  always_comb begin
    w_parked = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (w_pending_kept[s] && (r_parked_id[s] == ID_W'(m))) begin
          w_parked[m] = 1'b1;
        end
      end
    end
  end

  assign w_eligible = bus.m_request & ~w_parked;

  // Lowest-index slave wins when several resumes land in the same cycle.
  always_comb begin
    w_new_res_valid = 1'b0;
    w_new_res_id    = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if (w_resume_hit[s]) begin
        w_new_res_valid = 1'b1;
        w_new_res_id    = r_parked_id[s];
      end
    end
  end

  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    if (ROUND_ROBIN != 0) begin
      for (int off = 1; off <= NUM_MASTERS; off++) begin
        if (!w_win_valid && w_eligible[(int'(r_rr_ptr) + off) % NUM_MASTERS]) begin
          w_win_valid = 1'b1;
          w_win_id    = ID_W'((int'(r_rr_ptr) + off) % NUM_MASTERS);
        end
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!w_win_valid && w_eligible[i]) begin
          w_win_valid = 1'b1;
          w_win_id    = ID_W'(i);
        end
      end
    end
    // A freshly resumed master pre-empts the normal policy.
    if (w_new_res_valid && w_eligible[w_new_res_id]) begin
      w_win_valid = 1'b1;
      w_win_id    = w_new_res_id;
    end else if (r_resume_valid && w_eligible[r_resume_id]) begin
      w_win_valid = 1'b1;
      w_win_id    = r_resume_id;
    end
  end

  // trans_done beats a split; a slave already holding a parked master ignores it.
  always_comb begin
    w_split_set = '0;
    if (r_state == S_BUSY && !bus.trans_done) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (int'(r_slave_sel) == s && bus.s_split_en[s] && !r_split_pending[s]) begin
          w_split_set[s] = 1'b1;
        end
      end
    end
  end

  assign w_split_fire = |w_split_set;

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_COUNT_TIMEOUT + 1);
  logic [WD_W-1:0] r_wd_count;

  always_ff @(posedge clk) begin
    if (reset || r_state != S_BUSY) begin
      r_wd_count <= '0;
    end else begin
      r_wd_count <= r_wd_count + 1'b1;
    end
  end

  assign w_wd_fire = (r_state == S_BUSY) && !bus.trans_done && !w_split_fire &&
                     (r_wd_count == WD_W'(MAX_COUNT_TIMEOUT - 1));
`else
  // No watchdog; the parameter is only referenced to keep it in use.
  assign w_wd_fire = 1'b0 & (MAX_COUNT_TIMEOUT > 0);
`endif

  assign w_release = (r_state == S_BUSY) && (bus.trans_done || w_split_fire || w_wd_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_win_valid) w_next_state = S_GRANT;
      S_GRANT: w_next_state = S_BUSY;
      S_BUSY:  if (w_release) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_arbiter_busy = 1'b0;
    w_bus_busy     = 1'b0;
    case (r_state)
      S_GRANT: w_arbiter_busy = 1'b1;
      S_BUSY: begin
        w_arbiter_busy = 1'b1;
        w_bus_busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant         <= '0;
      r_grant_id      <= '0;
      r_slave_sel     <= '0;
      r_rr_ptr        <= ID_W'(NUM_MASTERS - 1);
      r_split_pending <= '0;
      r_resume_valid  <= 1'b0;
      r_resume_id     <= '0;
      r_timeout       <= 1'b0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        r_parked_id[s] <= '0;
      end
    end else begin
      r_timeout <= w_wd_fire;
      if (r_state == S_IDLE && w_win_valid) begin
        r_grant     <= NUM_MASTERS'(1) << w_win_id;
        r_grant_id  <= w_win_id;
        r_slave_sel <= bus.m_slave_sel[w_win_id*SLAVE_LEN +: SLAVE_LEN];
        r_rr_ptr    <= w_win_id;
      end else if (w_release) begin
        r_grant <= '0;
      end

      r_split_pending <= w_pending_kept | w_split_set;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (w_split_set[s]) begin
          r_parked_id[s] <= r_grant_id;
        end
      end

      if (r_state == S_IDLE && w_win_valid) begin
        r_resume_valid <= 1'b0;
      end else if (w_new_res_valid && !r_resume_valid) begin
        r_resume_valid <= 1'b1;
        r_resume_id    <= w_new_res_id;
      end
    end
  end

  assign bus.m_grant       = r_grant;
  assign bus.grant_id      = r_grant_id;
  assign bus.slave_sel     = r_slave_sel;
  assign bus.arbiter_busy  = w_arbiter_busy;
  assign bus.bus_busy      = w_bus_busy;
  assign bus.split_pending = r_split_pending;
  assign bus.timeout       = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_multi_master_arbiter.sv
// ============================================================================
// tb_multi_master_arbiter : directed bench for multi_master_arbiter (RR + fixed).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multi_master_arbiter;
  localparam int NM   = 4;
  localparam int NS   = 3;
  localparam int SL   = 2;
  localparam int MAXC = 100;

  logic clk;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [NM-1:0] exp_q [$];

  multi_master_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL)) bus_a ();
  multi_master_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL)) bus_b ();

  multi_master_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL),
    .ROUND_ROBIN(1), .MAX_COUNT_TIMEOUT(MAXC)
  ) dut_rr (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  multi_master_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL),
    .ROUND_ROBIN(0), .MAX_COUNT_TIMEOUT(MAXC)
  ) dut_fp (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NM-1:0] get_grant(input bit sel);
    return sel ? bus_b.m_grant : bus_a.m_grant;
  endfunction

  function automatic logic [1:0] get_id(input bit sel);
    return sel ? bus_b.grant_id : bus_a.grant_id;
  endfunction

  function automatic int oh2idx(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Waits (bounded) for a grant, then pops the scoreboard and checks owner and latency.
  task automatic wait_grant(input bit sel, input string tag);
    int            n;
    logic [NM-1:0] g;
    logic [NM-1:0] e;
    n = 0;
    g = get_grant(sel);
    while (g == '0 && n < 20) begin
      tick();
      n++;
      g = get_grant(sel);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_grant"}, 32'(g), 32'(e));
    check({tag, "_id"}, 32'(get_id(sel)), 32'(oh2idx(e)));
    check({tag, "_latency"}, 32'(n), 32'd1);
  endtask

  task automatic pulse_done(input bit sel);
    if (sel) bus_b.trans_done = 1'b1; else bus_a.trans_done = 1'b1;
    tick();
    bus_a.trans_done = 1'b0;
    bus_b.trans_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset                = 1'b1;
    bus_a.m_request      = '0;
    bus_a.m_slave_sel    = '0;
    bus_a.trans_done     = 1'b0;
    bus_a.s_split_en     = '0;
    bus_a.s_split_resume = '0;
    bus_b.m_request      = '0;
    bus_b.m_slave_sel    = '0;
    bus_b.trans_done     = 1'b0;
    bus_b.s_split_en     = '0;
    bus_b.s_split_resume = '0;
    tick();
    tick();
    check("rst_grant",   32'(bus_a.m_grant), 32'h0);
    check("rst_id",      32'(bus_a.grant_id), 32'h0);
    check("rst_ssel",    32'(bus_a.slave_sel), 32'h0);
    check("rst_arbbusy", 32'(bus_a.arbiter_busy), 32'h0);
    check("rst_busbusy", 32'(bus_a.bus_busy), 32'h0);
    check("rst_pending", 32'(bus_a.split_pending), 32'h0);
    check("rst_timeout", 32'(bus_a.timeout), 32'h0);
    check("rst_fp_grant", 32'(bus_b.m_grant), 32'h0);
    reset = 1'b0;

    // Single request, master 2 on slave 1
    bus_a.m_slave_sel = 8'b00_01_00_00;
    bus_a.m_request   = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant(0, "single");
    check("single_arbbusy", 32'(bus_a.arbiter_busy), 32'h1);
    check("single_busbusy_grant", 32'(bus_a.bus_busy), 32'h0);
    check("single_ssel", 32'(bus_a.slave_sel), 32'h1);
    tick();
    check("single_busbusy", 32'(bus_a.bus_busy), 32'h1);
    bus_a.m_request = '0;
    tick();
    check("req_drop_hold", 32'(bus_a.m_grant), 32'h4);
    pulse_done(0);
    check("done_grant", 32'(bus_a.m_grant), 32'h0);
    check("done_idle", 32'(bus_a.arbiter_busy), 32'h0);

    // Round robin, all requesting
    do_reset();
    bus_a.m_request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(4'(1 << (k % 4)));
      wait_grant(0, "rr");
      tick();
      pulse_done(0);
    end
    bus_a.m_request = '0;

    // Split / resume: m0,m1 -> slave 2, m3 -> slave 0
    do_reset();
    bus_a.m_slave_sel = 8'b00_00_10_10;
    bus_a.m_request   = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(0, "split_m1");
    check("split_m1_ssel", 32'(bus_a.slave_sel), 32'h2);
    tick();
    bus_a.s_split_en = 3'b100;
    tick();
    bus_a.s_split_en = '0;
    check("split_pending", 32'(bus_a.split_pending), 32'h4);
    check("split_grant_clr", 32'(bus_a.m_grant), 32'h0);
    check("split_idle", 32'(bus_a.arbiter_busy), 32'h0);
    tick();
    tick();
    check("all_parked_idle", 32'(bus_a.arbiter_busy), 32'h0);
    check("all_parked_grant", 32'(bus_a.m_grant), 32'h0);
    bus_a.m_request = 4'b1010;
    exp_q.push_back(4'b1000);
    wait_grant(0, "split_m3");
    tick();
    bus_a.m_request      = 4'b1011;
    bus_a.s_split_resume = 3'b001;
    tick();
    bus_a.s_split_resume = '0;
    check("resume_ignored", 32'(bus_a.split_pending), 32'h4);
    bus_a.s_split_resume = 3'b100;
    tick();
    bus_a.s_split_resume = '0;
    check("resume_clr", 32'(bus_a.split_pending), 32'h0);
    check("resume_owner_kept", 32'(bus_a.m_grant), 32'h8);
    exp_q.push_back(4'b0010);
    pulse_done(0);
    wait_grant(0, "resume_m1");
    tick();
    bus_a.m_request  = 4'b0011;
    bus_a.s_split_en = 3'b100;
    tick();
    bus_a.s_split_en = '0;
    check("repark_pending", 32'(bus_a.split_pending), 32'h4);
    exp_q.push_back(4'b0001);
    wait_grant(0, "m0_after_park");
    check("m0_ssel", 32'(bus_a.slave_sel), 32'h2);
    tick();
    bus_a.s_split_en = 3'b100;
    tick();
    bus_a.s_split_en = '0;
    check("second_split_grant", 32'(bus_a.m_grant), 32'h1);
    check("second_split_busy", 32'(bus_a.bus_busy), 32'h1);
    check("second_split_pending", 32'(bus_a.split_pending), 32'h4);
    bus_a.m_request = '0;
    pulse_done(0);

    // Collision: trans_done with split on the owner's slave
    do_reset();
    bus_a.m_slave_sel = 8'b00_00_00_01;
    bus_a.m_request   = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(0, "coll");
    bus_a.m_request = '0;
    tick();
    bus_a.trans_done = 1'b1;
    bus_a.s_split_en = 3'b010;
    tick();
    bus_a.trans_done = 1'b0;
    bus_a.s_split_en = '0;
    check("coll_pending", 32'(bus_a.split_pending), 32'h0);
    check("coll_grant", 32'(bus_a.m_grant), 32'h0);
    check("coll_idle", 32'(bus_a.arbiter_busy), 32'h0);

    // Out-of-range slave select ignores splits
    bus_a.m_slave_sel = 8'b00_00_00_11;
    bus_a.m_request   = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(0, "oor");
    bus_a.m_request = '0;
    check("oor_ssel", 32'(bus_a.slave_sel), 32'h3);
    tick();
    bus_a.s_split_en = 3'b111;
    tick();
    bus_a.s_split_en = '0;
    check("oor_grant", 32'(bus_a.m_grant), 32'h1);
    check("oor_pending", 32'(bus_a.split_pending), 32'h0);
    check("oor_busy", 32'(bus_a.bus_busy), 32'h1);
    pulse_done(0);

    // Watchdog
    bus_a.m_request = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(0, "wd");
    bus_a.m_request = '0;
    n = 0;
    while (bus_a.timeout !== 1'b1 && n < 150) begin
      tick();
      n++;
    end
`ifdef ARB_WATCHDOG_EN
    check("wd_cycles", 32'(n), 32'(MAXC + 1));
    check("wd_grant", 32'(bus_a.m_grant), 32'h0);
    check("wd_idle", 32'(bus_a.arbiter_busy), 32'h0);
    tick();
    check("wd_pulse_end", 32'(bus_a.timeout), 32'h0);
`else
    check("nowd_cycles", 32'(n), 32'd150);
    check("nowd_grant", 32'(bus_a.m_grant), 32'h1);
    check("nowd_busy", 32'(bus_a.bus_busy), 32'h1);
`endif
    pulse_done(0);

    // Reset mid-transaction
    bus_a.m_request = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(0, "midrst");
    tick();
    bus_a.m_request = '0;
    reset = 1'b1;
    tick();
    check("midrst_grant", 32'(bus_a.m_grant), 32'h0);
    check("midrst_busbusy", 32'(bus_a.bus_busy), 32'h0);
    check("midrst_arbbusy", 32'(bus_a.arbiter_busy), 32'h0);
    reset = 1'b0;

    // Fixed priority instance, all requesting
    bus_b.m_request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(4'b0001);
      wait_grant(1, "fp");
      tick();
      pulse_done(1);
    end
    bus_b.m_request = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_master_arbiter.md
MULTI_MASTER_ARBITER -- requirements
Module: multi_master_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, SHALL set the number of requesting masters (2..8).
REQ-002 Parameter NUM_SLAVES, default 3, SHALL set the number of split-capable slaves (1..4).
REQ-003 Parameter SLAVE_LEN, default 2, SHALL set the slave-select width.
REQ-004 Parameter ROUND_ROBIN, default 1, SHALL select the arbitration policy: 1 = rotating, 0 = fixed priority.
REQ-005 Parameter MAX_COUNT_TIMEOUT, default 100, SHALL set the watchdog limit in cycles.
REQ-006 clk  in  1  bus clock; single clock domain.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 m_request  in  NUM_MASTERS  per-master bus request, level.
REQ-009 m_slave_sel  in  NUM_MASTERS*SLAVE_LEN  per-master target slave; master i occupies bits [i*SLAVE_LEN +: SLAVE_LEN].
REQ-010 trans_done  in  1  one-cycle pulse from the owning master at end of transaction.
REQ-011 s_split_en  in  NUM_SLAVES  slave requests a split of the current transaction.
REQ-012 s_split_resume  in  NUM_SLAVES  slave ready to resume its parked master, one-cycle pulse.
REQ-013 m_grant  out  NUM_MASTERS  one-hot grant.
REQ-014 grant_id  out  $clog2(NUM_MASTERS)  index of the granted master.
REQ-015 slave_sel  out  SLAVE_LEN  target slave of the current owner, for the data muxes.
REQ-016 arbiter_busy  out  1  high in GRANT and BUSY.
REQ-017 bus_busy  out  1  high in BUSY only.
REQ-018 split_pending  out  NUM_SLAVES  slave s holds a parked master.
REQ-019 timeout  out  1  one-cycle pulse on watchdog release.

Function
REQ-020 FSM states SHALL be IDLE, GRANT, and BUSY.
REQ-021 IDLE->GRANT SHALL occur on the first cycle any eligible request is present. A request is eligible when m_request is high and the master is not parked.
REQ-022 In IDLE->GRANT, m_grant, grant_id and slave_sel SHALL be registered, giving a grant latency of 1 cycle after the request is sampled.
REQ-023 GRANT->BUSY SHALL occur unconditionally after 1 cycle.
REQ-024 BUSY->IDLE SHALL occur on trans_done; m_grant SHALL clear on the same edge.
REQ-025 Resume priority: a master unparked by s_split_resume SHALL win the next arbitration over all other requests. If several are unparked, the lowest slave index wins.
REQ-026 ROUND_ROBIN=1: search SHALL start at (last grant_id+1) mod NUM_MASTERS; the pointer SHALL update only on GRANT entry.
REQ-027 ROUND_ROBIN=0: the lowest eligible index SHALL win.
REQ-028 In BUSY, if s_split_en[slave_sel] is high and trans_done is low, the arbiter SHALL park the owner against that slave, set split_pending[slave_sel], clear m_grant, and return to IDLE next cycle.
REQ-029 s_split_resume[s] SHALL clear split_pending[s] and unpark its master. A resume pulse for a slave with no parked master SHALL be ignored.
REQ-030 A second split on a slave already holding a parked master SHALL be ignored; the transaction continues in BUSY.
REQ-031 A simultaneous trans_done and s_split_en SHALL be resolved in favour of trans_done, with no park.
REQ-032 If slave_sel is >= NUM_SLAVES, split inputs SHALL be ignored for that transaction.
REQ-033 A request deasserting during GRANT/BUSY SHALL NOT revoke the grant; only trans_done, a split or a timeout releases the bus.
REQ-034 If all requesters are parked, the arbiter SHALL stay in IDLE.

Reset
REQ-035 While reset is high, the following SHALL hold: state=IDLE, m_grant=0, grant_id=0, slave_sel=0, arbiter_busy=0, bus_busy=0, split_pending=0, timeout=0, round-robin pointer=NUM_MASTERS-1, all parked records cleared.
REQ-036 A reset asserted mid-transaction SHALL take effect on the next edge, with no completion of the transaction.

Configuration
REQ-037 Macro ARB_WATCHDOG_EN, when defined, SHALL add a BUSY-cycle counter. On reaching MAX_COUNT_TIMEOUT without trans_done, the arbiter SHALL pulse timeout, clear the grant, and go to IDLE. The counter SHALL clear on BUSY entry.
REQ-038 Without ARB_WATCHDOG_EN, no counter SHALL be built, timeout SHALL be tied 0, and BUSY SHALL persist until trans_done or a split.

Verification
REQ-039 Single request: reset, m_request=4'b0100 -> m_grant=4'b0100 one cycle later, bus_busy the next cycle; trans_done -> m_grant=0 and IDLE.
REQ-040 Round robin: ROUND_ROBIN=1, m_request=4'b1111 held, trans_done after each grant -> grant order 0,1,2,3,0.
REQ-041 Fixed priority: ROUND_ROBIN=0, same stimulus -> master 0 granted every time.
REQ-042 Split/resume: master 1 on slave 2, s_split_en[2] in BUSY -> split_pending=3'b100 and master 3 granted. Then s_split_resume[2] while masters 0 and 3 request -> master 1 granted next.
REQ-043 Collision: trans_done and s_split_en same cycle -> split_pending stays 0.
REQ-044 Watchdog: with ARB_WATCHDOG_EN and MAX_COUNT_TIMEOUT=100, no trans_done -> timeout pulses after 100 BUSY cycles and m_grant=0; without the macro, the grant is held.
